// File: rtl/reaction_multi_round.sv
// Multi-round reaction-time game core: random wait, ms-timed response, per-round and average score, best-average high score.
// Optional build macro REACTION_FALSE_START_EN: a press during the wait becomes a foul round scored as MAX.
module reaction_multi_round #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCORE_W      = 12,
  parameter int ROUNDS       = 4,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_W       = 10
) (
  input  logic                      clk,
  input  logic                      iReset,
  input  logic                      spacePressed,
  input  logic                      onePressed,
  output logic [2:0]                screen,
  output logic [SCORE_W-1:0]        currentScore,
  output logic [SCORE_W-1:0]        highScore,
  output logic [$clog2(ROUNDS):0]   roundIdx
);

  localparam int DIV     = CLK_HZ / 1000;
  localparam int PRESC_W = $clog2(DIV + 1);
  localparam int LOG2_R  = $clog2(ROUNDS);
  localparam int RIDX_W  = LOG2_R + 1;
  localparam int SUM_W   = SCORE_W + LOG2_R;
  localparam int DELAY_W = $clog2(MIN_DELAY_MS + (1 << RAND_W));
  localparam logic [SCORE_W-1:0] MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_GO      = 3'd2,
    S_RESULT  = 3'd3,
    S_SUMMARY = 3'd4,
    S_FOUL    = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [15:0]          lfsr;
  logic [PRESC_W-1:0]   presc, presc_n;
  logic [DELAY_W-1:0]   delay, delay_n;
  logic [SCORE_W-1:0]   up, up_n;
  logic [SCORE_W-1:0]   score_n, high_n;
  logic [SUM_W-1:0]     sum, sum_n;
  logic [RIDX_W-1:0]    round_n;
  logic                 tick;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == MAX) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [SCORE_W-1:0] average(input logic [SUM_W-1:0] s);
    return SCORE_W'(s >> LOG2_R);
  endfunction

  function automatic logic [DELAY_W-1:0] new_delay(input logic [15:0] l);
    return DELAY_W'(MIN_DELAY_MS) + DELAY_W'(l[RAND_W-1:0]);
  endfunction

  assign tick   = (presc == PRESC_W'(DIV - 1));
  assign screen = state;

  always_comb begin
    state_n = state;
    presc_n = '0;
    delay_n = delay;
    up_n    = up;
    score_n = currentScore;
    sum_n   = sum;
    high_n  = highScore;
    round_n = roundIdx;
    // Prescaler only runs while timing; any other state parks it at zero so entry restarts it.
    if (state == S_WAIT || state == S_GO)
      presc_n = tick ? '0 : presc + PRESC_W'(1);

    if (onePressed) begin
      state_n = S_IDLE;
      round_n = '0;
      presc_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (spacePressed) begin
            state_n = S_WAIT;
            round_n = '0;
            sum_n   = '0;
            delay_n = new_delay(lfsr);
            presc_n = '0;
          end
        end
        S_WAIT: begin
`ifdef REACTION_FALSE_START_EN
          if (spacePressed) begin
            state_n = S_FOUL;
            score_n = MAX;
            sum_n   = sum + SUM_W'(MAX);
          end else
`endif
          if (tick) begin
            delay_n = delay - DELAY_W'(1);
            if (delay <= DELAY_W'(1)) begin
              state_n = S_GO;
              up_n    = '0;
              presc_n = '0;
            end
          end
        end
        S_GO: begin
          if (spacePressed) begin
            state_n = S_RESULT;
            score_n = up;
            sum_n   = sum + SUM_W'(up);
          end else if (tick) begin
            up_n = sat_inc(up);
            if (up == MAX - SCORE_W'(1)) begin
              state_n = S_RESULT;
              score_n = MAX;
              sum_n   = sum + SUM_W'(MAX);
            end
          end
        end
        S_RESULT, S_FOUL: begin
          if (spacePressed) begin
            if (roundIdx < RIDX_W'(ROUNDS - 1)) begin
              state_n = S_WAIT;
              round_n = roundIdx + RIDX_W'(1);
              delay_n = new_delay(lfsr);
              presc_n = '0;
            end else begin
              state_n = S_SUMMARY;
              score_n = average(sum);
              if (average(sum) < highScore)
                high_n = average(sum);
            end
          end
        end
        S_SUMMARY: begin
          if (spacePressed) begin
            state_n = S_IDLE;
            round_n = '0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      state        <= S_IDLE;
      lfsr         <= 16'hACE1;
      presc        <= '0;
      delay        <= '0;
      up           <= '0;
      sum          <= '0;
      currentScore <= '0;
      highScore    <= MAX;
      roundIdx     <= '0;
    end else begin
      state        <= state_n;
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      presc        <= presc_n;
      delay        <= delay_n;
      up           <= up_n;
      sum          <= sum_n;
      currentScore <= score_n;
      highScore    <= high_n;
      roundIdx     <= round_n;
    end
  end

endmodule
